// File: rtl/sysid_info_bank.sv
// -----------------------------------------------------------------------------
// sysid_info_bank
// Read-mostly system identification register bank on a simple memory-mapped
// bus. Provides ID and build timestamp words, a capability word, a byte-lane
// writable scratch register, a free-running 64-bit uptime counter with a
// coherent high-word shadow, a control register (freeze / clear) and up to
// eight read-only user information words.
//
// Ports
//   clock         : single clock, all logic on the rising edge
//   reset         : synchronous active-high reset
//   address[3:0]  : word address
//   read          : read strobe (fixed one-cycle latency, never stalled)
//   write         : write strobe
//   writedata     : write data
//   byteenable    : write byte lanes (SCRATCH only)
//   user_info     : NUM_USER packed 32-bit user words, word k at [32k+31:32k]
//   readdata      : registered read data, zero when readdatavalid is low
//   readdatavalid : qualifies readdata for exactly one cycle per read
// -----------------------------------------------------------------------------
module sysid_info_bank #(
    parameter logic [31:0] ID_VALUE  = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
    parameter int          NUM_USER  = 4,
    parameter int          TICK_DIV  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [3:0]               address,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              writedata,
    input  logic [3:0]               byteenable,
    input  logic [NUM_USER*32-1:0]   user_info,
    output logic [31:0]              readdata,
    output logic                     readdatavalid
);

    localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
    localparam logic [7:0]  NUM_USER_B = 8'(NUM_USER);

    localparam logic [3:0] ADDR_ID        = 4'd0;
    localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
    localparam logic [3:0] ADDR_CAPS      = 4'd2;
    localparam logic [3:0] ADDR_SCRATCH   = 4'd3;
    localparam logic [3:0] ADDR_UPTIME_LO = 4'd4;
    localparam logic [3:0] ADDR_UPTIME_HI = 4'd5;
    localparam logic [3:0] ADDR_CTRL      = 4'd6;

    logic [15:0] prescaler_r;
    logic [63:0] uptime_r;
    logic [31:0] hi_shadow_r;
    logic [31:0] scratch_r;
    logic        freeze_r;
    logic [31:0] readdata_r;
    logic        readdatavalid_r;

    logic [31:0] user_words_s [0:7];
    logic [31:0] read_mux_s;
    logic        clear_s;
    logic        ctrl_wr_s;
    logic        scratch_wr_s;
    logic        lo_rd_s;
    logic        tick_s;

    // Pad the user words out to the full 8-entry window; absent words read 0.
    for (genvar k = 0; k < 8; k++) begin : g_user
        if (k < NUM_USER) begin : g_present
            assign user_words_s[k] = user_info[k*32 +: 32];
        end else begin : g_absent
            assign user_words_s[k] = 32'd0;
        end
    end

    assign ctrl_wr_s    = write && (address == ADDR_CTRL);
    assign scratch_wr_s = write && (address == ADDR_SCRATCH);
    assign clear_s      = ctrl_wr_s && writedata[0];
    assign lo_rd_s      = read && (address == ADDR_UPTIME_LO);
    assign tick_s       = !freeze_r && (prescaler_r == TICK_LAST);

    // Read multiplexer: always reflects pre-write state of this cycle.
    always_comb begin
        read_mux_s = 32'd0;
        case (address)
            ADDR_ID:        read_mux_s = ID_VALUE;
            ADDR_TIMESTAMP: read_mux_s = TIMESTAMP;
            ADDR_CAPS:      read_mux_s = {16'h0001, 8'd0, NUM_USER_B};
            ADDR_SCRATCH:   read_mux_s = scratch_r;
            ADDR_UPTIME_LO: read_mux_s = uptime_r[31:0];
            ADDR_UPTIME_HI: read_mux_s = hi_shadow_r;
            ADDR_CTRL:      read_mux_s = {30'd0, freeze_r, 1'b0};
            4'd8, 4'd9, 4'd10, 4'd11,
            4'd12, 4'd13, 4'd14, 4'd15:
                            read_mux_s = user_words_s[address[2:0]];
            default:        read_mux_s = 32'd0;
        endcase
    end

    // Prescaler and uptime counter; a clear wins over a same-cycle tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler_r <= 16'd0;
            uptime_r    <= 64'd0;
        end else if (clear_s) begin
            prescaler_r <= 16'd0;
            uptime_r    <= 64'd0;
        end else if (tick_s) begin
            prescaler_r <= 16'd0;
            uptime_r    <= uptime_r + 64'd1;
        end else if (!freeze_r) begin
            prescaler_r <= prescaler_r + 16'd1;
        end
    end

    // HI shadow captures the upper word from the same pre-increment value
    // returned by the LO read, so LO then HI forms a coherent 64-bit sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_shadow_r <= 32'd0;
        end else if (lo_rd_s) begin
            hi_shadow_r <= uptime_r[63:32];
        end
    end

    // SCRATCH byte-lane writes and CTRL freeze bit (CTRL ignores byteenable).
    always_ff @(posedge clock) begin
        if (reset) begin
            scratch_r <= 32'd0;
            freeze_r  <= 1'b0;
        end else begin
            if (scratch_wr_s) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) begin
                        scratch_r[b*8 +: 8] <= writedata[b*8 +: 8];
                    end
                end
            end
            if (ctrl_wr_s) begin
                freeze_r <= writedata[1];
            end
        end
    end

    // Registered read response: one-cycle latency, data forced to 0 when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_r      <= 32'd0;
            readdatavalid_r <= 1'b0;
        end else if (read) begin
            readdata_r      <= read_mux_s;
            readdatavalid_r <= 1'b1;
        end else begin
            readdata_r      <= 32'd0;
            readdatavalid_r <= 1'b0;
        end
    end

    assign readdata      = readdata_r;
    assign readdatavalid = readdatavalid_r;

endmodule

// File: tb/tb_sysid_info_bank.sv
// -----------------------------------------------------------------------------
// Testbench for sysid_info_bank. Two instances share one bus: dut1 with
// TICK_DIV=1 and dut4 with TICK_DIV=4. A behavioural model tracks each
// instance: uptime is base + (running clocks since clear) / TICK_DIV.
// -----------------------------------------------------------------------------
module tb_sysid_info_bank;

    localparam logic [31:0] ID_VAL = 32'h619E_A55C;
    localparam logic [31:0] TS_VAL = 32'h2025_0307;
    localparam int          NU     = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [3:0]      address;
    logic            read;
    logic            write;
    logic [31:0]     writedata;
    logic [3:0]      byteenable;
    logic [NU*32-1:0] user_info;
    logic [31:0]     dut_data [2];
    logic            dut_valid [2];

    sysid_info_bank #(.ID_VALUE(ID_VAL), .TIMESTAMP(TS_VAL), .NUM_USER(NU), .TICK_DIV(1)) dut1 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .user_info(user_info),
        .readdata(dut_data[0]), .readdatavalid(dut_valid[0])
    );

    sysid_info_bank #(.ID_VALUE(ID_VAL), .TIMESTAMP(TS_VAL), .NUM_USER(NU), .TICK_DIV(4)) dut4 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .user_info(user_info),
        .readdata(dut_data[1]), .readdatavalid(dut_valid[1])
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model state, index 0 = dut1, index 1 = dut4.
    logic [63:0] m_base [2];
    logic [63:0] m_run [2];
    logic [31:0] m_shadow [2];
    logic [31:0] m_scratch [2];
    logic        m_freeze [2];
    logic [31:0] exp_data [2];
    logic        exp_valid [2];

    function automatic int td(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [63:0] m_uptime(input int i);
        return m_base[i] + (m_run[i] / 64'(td(i)));
    endfunction

    function automatic logic [31:0] m_read(input int i, input logic [3:0] a);
        logic [63:0] up;
        int          idx;
        up  = m_uptime(i);
        idx = int'(a) - 8;
        case (a)
            4'd0:    return ID_VAL;
            4'd1:    return TS_VAL;
            4'd2:    return {16'h0001, 8'h00, 8'(NU)};
            4'd3:    return m_scratch[i];
            4'd4:    return up[31:0];
            4'd5:    return m_shadow[i];
            4'd6:    return {30'd0, m_freeze[i], 1'b0};
            default: return (idx >= 0 && idx < NU) ? user_info[idx*32 +: 32] : 32'd0;
        endcase
    endfunction

    // One bus cycle: drive inputs, advance the model, wait for the edge, settle.
    task automatic cycle(input logic rd, input logic wr, input logic [3:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input logic rst);
        logic [63:0] up;
        reset = rst; read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        for (int k = 0; k < NU; k++) user_info[k*32 +: 32] = $urandom();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_base[i] = 64'd0; m_run[i] = 64'd0; m_shadow[i] = 32'd0;
                m_scratch[i] = 32'd0; m_freeze[i] = 1'b0;
                exp_data[i] = 32'd0; exp_valid[i] = 1'b0;
            end else begin
                up = m_uptime(i);
                exp_data[i]  = rd ? m_read(i, a) : 32'd0;
                exp_valid[i] = rd;
                if (rd && a == 4'd4) m_shadow[i] = up[63:32];
                if (wr && a == 4'd6 && wd[0]) begin
                    m_base[i] = 64'd0; m_run[i] = 64'd0;
                end else if (!m_freeze[i]) begin
                    m_run[i] = m_run[i] + 64'd1;
                end
                if (wr && a == 4'd3)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) m_scratch[i][b*8 +: 8] = wd[b*8 +: 8];
                if (wr && a == 4'd6) m_freeze[i] = wd[1];
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b1, 4'd3, 32'hFFFF_FFFF, 4'hF, 1'b1);
        cycle(1'b1, 1'b0, 4'd0, 32'd0, 4'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_data[i] !== 32'd0 || dut_valid[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %h/%b want 00000000/0", i, dut_data[i], dut_valid[i]);
            end
        end
        for (int a = 3; a <= 6; a++) begin
            cycle(1'b1, 1'b0, 4'(a), 32'd0, 4'h0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ((a != 4 && dut_data[i] !== 32'd0) || dut_data[i] !== exp_data[i] || dut_valid[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_regs a=%0d dut%0d: got %h/%b want %h/1", a, i, dut_data[i], dut_valid[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_id_caps;
        logic [31:0] want;
        for (int a = 0; a < 3; a++) begin
            want = (a == 0) ? 32'h619E_A55C : (a == 1) ? TS_VAL : 32'h0001_0004;
            cycle(1'b1, 1'b0, 4'(a), 32'd0, 4'h0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_data[i] !== want || dut_valid[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL id_caps a=%0d dut%0d: got %h/%b want %h/1", a, i, dut_data[i], dut_valid[i], want);
                end
            end
        end
        cycle(1'b0, 1'b0, 4'd0, 32'd0, 4'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_data[i] !== 32'd0 || dut_valid[i] !== 1'b0) begin
                errors++;
                $display("FAIL idle_zero dut%0d: got %h/%b want 00000000/0", i, dut_data[i], dut_valid[i]);
            end
        end
    endtask

    task automatic test_scratch;
        logic [31:0] wd;
        cycle(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 4'b0101, 1'b0);
        cycle(1'b1, 1'b0, 4'd3, 32'd0, 4'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_data[i] !== 32'h00AD_00EF || dut_valid[i] !== 1'b1) begin
                errors++;
                $display("FAIL scratch_lanes dut%0d: got %h want 00ad00ef", i, dut_data[i]);
            end
        end
        for (int n = 0; n < 12; n++) begin
            wd = $urandom();
            cycle(1'b0, 1'b1, 4'd3, wd, 4'($urandom_range(0, 15)), 1'b0);
            cycle(1'b1, ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 2)), wd, 4'hF, 1'b0);
            cycle(1'b1, 1'b0, 4'd3, 32'd0, 4'h0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_data[i] !== exp_data[i] || dut_valid[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL scratch_rand dut%0d: got %h want %h", i, dut_data[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_user_and_holes;
        logic [3:0] a;
        for (int n = 0; n < 16; n++) begin
            a = (n == 0) ? 4'd7 : (n == 1) ? 4'd12 : 4'($urandom_range(7, 15));
            cycle(1'b1, 1'b1, a, $urandom(), 4'hF, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_data[i] !== exp_data[i] || dut_valid[i] !== 1'b1 || (a == 4'd7 || a >= 4'd12) && dut_data[i] !== 32'd0) begin
                    errors++;
                    $display("FAIL user_read a=%0d dut%0d: got %h want %h", a, i, dut_data[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_rw_same;
        logic [31:0] old_val;
        logic [31:0] new_val;
        for (int n = 0; n < 4; n++) begin
            old_val = m_scratch[0];
            new_val = $urandom();
            cycle(1'b1, 1'b1, 4'd3, new_val, 4'hF, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_data[i] !== old_val || dut_valid[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL rw_same_old dut%0d: got %h want %h", i, dut_data[i], old_val);
                end
            end
            cycle(1'b1, 1'b0, 4'd3, 32'd0, 4'h0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_data[i] !== new_val) begin
                    errors++;
                    $display("FAIL rw_same_new dut%0d: got %h want %h", i, dut_data[i], new_val);
                end
            end
        end
    endtask

    task automatic test_uptime_carry;
        logic [31:0] want [3];
        int          steps;
        for (int round = 0; round < 2; round++) begin
            cycle(1'b0, 1'b1, 4'd6, 32'd2, 4'h0, 1'b0);
            force dut1.uptime_r = 64'h0000_0000_FFFF_FFFF;
            #1;
            release dut1.uptime_r;
            m_base[0] = 64'h0000_0000_FFFF_FFFF;
            m_run[0]  = 64'd0;
            cycle(1'b0, 1'b1, 4'd6, 32'd0, 4'h0, 1'b0);
            // round 0: LO then HI; round 1: LO, LO, HI
            want[0] = 32'hFFFF_FFFF;
            want[1] = (round == 0) ? 32'd0 : 32'd0;
            want[2] = 32'd1;
            steps = (round == 0) ? 2 : 3;
            for (int s = 0; s < steps; s++) begin
                cycle(1'b1, 1'b0, (s == steps - 1) ? 4'd5 : 4'd4, 32'd0, 4'h0, 1'b0);
                checks++;
                if (dut_data[0] !== want[s] || dut_data[0] !== exp_data[0] || dut_valid[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL carry r%0d s%0d dut1: got %h want %h", round, s, dut_data[0], want[s]);
                end
                checks++;
                if (dut_data[1] !== exp_data[1]) begin
                    errors++;
                    $display("FAIL carry_model r%0d s%0d dut4: got %h want %h", round, s, dut_data[1], exp_data[1]);
                end
            end
        end
    endtask

    task automatic test_freeze_clear;
        cycle(1'b0, 1'b1, 4'd6, 32'd2, 4'h0, 1'b0);
        for (int n = 0; n < 20; n++) cycle(1'b0, 1'b0, 4'd0, 32'd0, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 4'd4, 32'd0, 4'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL frozen_lo dut%0d: got %h want %h", i, dut_data[i], exp_data[i]);
            end
        end
        cycle(1'b0, 1'b1, 4'd6, 32'd1, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 4'd4, 32'd0, 4'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_data[i] !== 32'd0 || dut_valid[i] !== 1'b1) begin
                errors++;
                $display("FAIL clear_lo dut%0d: got %h want 00000000", i, dut_data[i]);
            end
        end
        for (int n = 0; n < 7; n++) cycle(1'b0, 1'b0, 4'd0, 32'd0, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 4'd4, 32'd0, 4'h0, 1'b0);
        checks++;
        if (dut_data[1] !== 32'd2) begin
            errors++;
            $display("FAIL div4_after8 dut4: got %h want 00000002", dut_data[1]);
        end
        checks++;
        if (dut_data[0] !== exp_data[0] || exp_data[0] !== 32'd8) begin
            errors++;
            $display("FAIL div1_after8 dut1: got %h want %h", dut_data[0], exp_data[0]);
        end
    endtask

    task automatic test_back_to_back;
        logic        wr;
        logic [3:0]  a;
        for (int n = 0; n < 60; n++) begin
            wr = ($urandom_range(0, 3) == 0);
            a  = 4'($urandom_range(0, 15));
            cycle(1'b1, wr, a, $urandom(), 4'($urandom_range(0, 15)), 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_data[i] !== exp_data[i] || dut_valid[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b n=%0d a=%0d dut%0d: got %h/%b want %h/1", n, a, i, dut_data[i], dut_valid[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_reset_burst;
        cycle(1'b0, 1'b1, 4'd3, 32'h1234_5678, 4'hF, 1'b0);
        cycle(1'b1, 1'b0, 4'd3, 32'd0, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 4'd0, 32'd0, 4'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_data[i] !== 32'd0 || dut_valid[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_burst dut%0d: got %h/%b want 00000000/0", i, dut_data[i], dut_valid[i]);
            end
        end
        for (int a = 3; a <= 6; a++) begin
            cycle(1'b1, 1'b0, 4'(a), 32'd0, 4'h0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_data[i] !== exp_data[i] || dut_valid[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL post_reset a=%0d dut%0d: got %h want %h", a, i, dut_data[i], exp_data[i]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = 4'd0;
        writedata = 32'd0; byteenable = 4'h0; user_info = '0;
        for (int i = 0; i < 2; i++) begin
            m_base[i] = 64'd0; m_run[i] = 64'd0; m_shadow[i] = 32'd0;
            m_scratch[i] = 32'd0; m_freeze[i] = 1'b0;
            exp_data[i] = 32'd0; exp_valid[i] = 1'b0;
        end
        test_reset();
        test_id_caps();
        test_scratch();
        test_user_and_holes();
        test_rw_same();
        test_uptime_carry();
        test_freeze_clear();
        test_back_to_back();
        test_reset_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
